// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared types and constants for the MIPS CPU control path.
//               - ifetch_state_t : instruction-fetch FSM states
//               - BE_WORD        : byte-enable pattern for a full-word access
//               - RESET_VECTOR   : boot address, shared with the PC block
// Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2
    } ifetch_state_t;

    localparam logic [3:0]  BE_WORD      = 4'hF;
    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage
`default_nettype wire

// File: rtl/mips_cpu_ifetch_perf.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_ifetch_perf
// Description : Fetch performance counters. Both counters are free-running
//               and wrap from 32'hFFFF_FFFF to 0.
// Ports       : clk, reset_n         clock, async active-low reset
//               fetch_done_i         a bus fetch completes this cycle
//               stall_i              fetch is held off by the bus this cycle
//               fetch_count_o        number of completed bus fetches
//               wait_count_o         number of bus wait cycles
// Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_ifetch_perf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        fetch_done_i,
    input  logic        stall_i,
    output logic [31:0] fetch_count_o,
    output logic [31:0] wait_count_o
);

    logic [31:0] fetch_cnt_q;
    logic [31:0] wait_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            if (fetch_done_i) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_i)      wait_cnt_q  <= wait_cnt_q + 32'd1;
        end
    end

    assign fetch_count_o = fetch_cnt_q;
    assign wait_count_o  = wait_cnt_q;

endmodule
`default_nettype wire

// File: rtl/mips_cpu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_ifetch
// Description : Instruction fetch unit. Issues one word read per FETCH phase
//               on an Avalon-style bus with waitrequest, captures the word
//               and holds it through EXEC. stall is raised while the bus
//               holds off. Misaligned PCs raise a sticky fetch_fault.
// Config      : MIPS_CPU_IFETCH_PERF_CNT_EN - builds fetch/wait counters;
//               when undefined fetch_count and wait_count read 0.
// Ports       : clk, reset_n         clock, async active-low reset
//               state                CPU phase (0 FETCH, 1 EXEC)
//               active               CPU running flag
//               pc_addr              byte address to fetch
//               mem_*                instruction-side bus
//               instruction_word     fetched instruction
//               stall                fetch outstanding, PC must hold
//               fetch_fault          sticky misaligned-fetch flag
//               fetch_count          completed bus fetches
//               wait_count           bus wait cycles
// Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_ifetch
    import mips_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        state,
    input  logic        active,
    input  logic [31:0] pc_addr,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] instruction_word,
    output logic        stall,
    output logic        fetch_fault,
    output logic [31:0] fetch_count,
    output logic [31:0] wait_count
);

    ifetch_state_t state_q, state_d;
    logic [31:0]   addr_q,  addr_d;
    logic [31:0]   instr_q, instr_d;
    logic          fault_q, fault_d;
    logic          w_fetch_req;

    // reset_n gates the launch so that the bus strobe drops the instant
    // reset asserts, even while the CPU is still presenting a FETCH phase.
    assign w_fetch_req = reset_n & ~state & active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            instr_q <= RESET_WORD;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        instr_d          = instr_q;
        fault_d          = fault_q;
        mem_read         = 1'b0;
        mem_address      = 32'd0;
        instruction_word = instr_q;

        case (state_q)
            IDLE: begin
                if (w_fetch_req) begin
                    if (pc_addr[1:0] == 2'b00) begin
                        mem_read    = 1'b1;
                        mem_address = pc_addr;
                        if (!mem_waitrequest) begin
                            // Zero-wait slave: bypass the data straight out.
                            instr_d          = mem_readdata;
                            instruction_word = mem_readdata;
                            state_d          = HELD;
                        end else begin
                            addr_d  = pc_addr;
                            state_d = WAIT;
                        end
                    end else begin
                        fault_d          = 1'b1;
                        instr_d          = RESET_WORD;
                        instruction_word = RESET_WORD;
                        state_d          = HELD;
                    end
                end
            end
            WAIT: begin
                // The read completes regardless of the CPU phase; a phase
                // change here is an upstream protocol error.
                mem_read    = 1'b1;
                mem_address = addr_q;
                if (!mem_waitrequest) begin
                    instr_d          = mem_readdata;
                    instruction_word = mem_readdata;
                    state_d          = HELD;
                end
            end
            HELD: begin
                if (state) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_byteenable = mem_read ? BE_WORD : 4'h0;
    assign stall          = mem_read & mem_waitrequest;
    assign fetch_fault    = fault_q;

`ifdef MIPS_CPU_IFETCH_PERF_CNT_EN
    logic w_fetch_done;
    assign w_fetch_done = mem_read & ~mem_waitrequest;

    mips_cpu_ifetch_perf u_perf (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_done_i  (w_fetch_done),
        .stall_i       (stall),
        .fetch_count_o (fetch_count),
        .wait_count_o  (wait_count)
    );
`else
    assign fetch_count = 32'd0;
    assign wait_count  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_ifetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_ifetch
// Description : Self-checking bench for mips_cpu_ifetch. A transaction-level
//               model of the fetch phase predicts every output each cycle;
//               directed scenarios add literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_ifetch;

    localparam logic [31:0] C_RESET_WORD = 32'h0000_0000;
`ifdef MIPS_CPU_IFETCH_PERF_CNT_EN
    localparam bit C_PERF = 1'b1;
`else
    localparam bit C_PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        state;
    logic        active;
    logic [31:0] pc_addr;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic [31:0] instruction_word;
    logic        stall;
    logic        fetch_fault;
    logic [31:0] fetch_count;
    logic [31:0] wait_count;

    int checks = 0;
    int failures = 0;

    mips_cpu_ifetch #(.RESET_WORD(C_RESET_WORD)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .state            (state),
        .active           (active),
        .pc_addr          (pc_addr),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdata     (mem_readdata),
        .mem_address      (mem_address),
        .mem_read         (mem_read),
        .mem_byteenable   (mem_byteenable),
        .instruction_word (instruction_word),
        .stall            (stall),
        .fetch_fault      (fetch_fault),
        .fetch_count      (fetch_count),
        .wait_count       (wait_count)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level model ----------------
    // m_pending : a bus read is outstanding (waitrequest seen)
    // m_done    : this FETCH phase has delivered its word (or faulted)
    bit          m_pending, m_done, m_fault;
    logic [31:0] m_paddr, m_word, m_fc, m_wc;

    task automatic mreset();
        m_pending = 0; m_done = 0; m_fault = 0;
        m_paddr = 0; m_word = C_RESET_WORD; m_fc = 0; m_wc = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit new_fetch();
        return !m_pending && !m_done && state == 1'b0 && active;
    endfunction

    function automatic bit issuing();
        return m_pending || (new_fetch() && pc_addr[1:0] == 2'b00);
    endfunction

    function automatic bit misaligned();
        return new_fetch() && pc_addr[1:0] != 2'b00;
    endfunction

    task automatic model_compare();
        logic [31:0] a, w;
        bit rd;
        rd = issuing();
        a  = rd ? (m_pending ? m_paddr : pc_addr) : 32'd0;
        if (rd && !mem_waitrequest) w = mem_readdata;
        else if (misaligned())      w = C_RESET_WORD;
        else                        w = m_word;
        chk("m_read",  {31'd0, mem_read}, {31'd0, rd});
        chk("m_addr",  mem_address, a);
        chk("m_be",    {28'd0, mem_byteenable}, rd ? 32'hF : 32'h0);
        chk("m_stall", {31'd0, stall}, {31'd0, rd && mem_waitrequest});
        chk("m_word",  instruction_word, w);
        chk("m_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
        chk("m_fcnt",  fetch_count, C_PERF ? m_fc : 32'd0);
        chk("m_wcnt",  wait_count,  C_PERF ? m_wc : 32'd0);
    endtask

    task automatic model_update();
        bit was_done;
        was_done = m_done;
        if (issuing()) begin
            if (!mem_waitrequest) begin
                m_word = mem_readdata; m_pending = 0; m_done = 1; m_fc++;
            end else begin
                if (!m_pending) m_paddr = pc_addr;
                m_pending = 1; m_wc++;
            end
        end else if (misaligned()) begin
            m_fault = 1; m_word = C_RESET_WORD; m_done = 1;
        end else if (was_done && state == 1'b1) begin
            m_done = 0;
        end
    endtask

    // Inputs are set at posedge+1; mid() lands on the falling edge.
    task automatic mid();
        #4;
        model_compare();
    endtask

    task automatic adv();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        mid();
        adv();
    endtask

    task automatic drive(input logic st, input logic act, input logic [31:0] pc,
                         input logic wr, input logic [31:0] rd);
        state = st; active = act; pc_addr = pc; mem_waitrequest = wr; mem_readdata = rd;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        mreset();
    endtask

    int stall_cnt;

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        mreset();
        @(posedge clk); #1;
        do_reset();

        // Reset state, pinned literally
        mid();
        chk("rst_read",  {31'd0, mem_read}, 32'd0);
        chk("rst_addr",  mem_address, 32'd0);
        chk("rst_be",    {28'd0, mem_byteenable}, 32'd0);
        chk("rst_word",  instruction_word, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_fcnt",  fetch_count, 32'd0);
        adv();

        // Zero-wait fetch from the boot vector
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h2402_0005);
        mid();
        chk("zw_read",  {31'd0, mem_read}, 32'd1);
        chk("zw_addr",  mem_address, 32'hBFC0_0000);
        chk("zw_stall", {31'd0, stall}, 32'd0);
        chk("zw_word",  instruction_word, 32'h2402_0005);
        adv();
        repeat (2) begin
            drive(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, $urandom);
            mid();
            chk("zw_hold", instruction_word, 32'h2402_0005);
            adv();
        end

        // Three wait cycles; PC wanders to prove the address is latched
        stall_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, (i == 0) ? 32'hBFC0_0004 : {$urandom_range(0, 255), 2'b00},
                  (i < 3), (i < 3) ? $urandom : 32'h8C22_0010);
            mid();
            if (stall) stall_cnt++;
            chk("ws_addr", mem_address, 32'hBFC0_0004);
            if (i == 3) chk("ws_word", instruction_word, 32'h8C22_0010);
            adv();
        end
        chk("ws_stalls", stall_cnt, 32'd3);
        drive(1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 32'd0);
        mid();
        chk("ws_wcnt", wait_count, C_PERF ? 32'd3 : 32'd0);
        chk("ws_fcnt", fetch_count, C_PERF ? 32'd2 : 32'd0);
        adv();

        // Misaligned fetch
        drive(1'b0, 1'b1, 32'hBFC0_0002, 1'b0, 32'h1234_5678);
        mid();
        chk("mis_read",  {31'd0, mem_read}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_word",  instruction_word, 32'd0);
        adv();
        drive(1'b1, 1'b1, 32'hBFC0_0002, 1'b0, 32'd0);
        mid();
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        adv();

        // Inactive CPU at exit address
        for (int i = 0; i < 10; i++) begin
            drive(i[0], 1'b0, 32'd0, $urandom_range(0, 1), $urandom);
            mid();
            chk("inact_read",  {31'd0, mem_read}, 32'd0);
            chk("inact_stall", {31'd0, stall}, 32'd0);
            adv();
        end

        // Async reset in the middle of a wait
        drive(1'b0, 1'b1, 32'hBFC0_0010, 1'b1, 32'd0);
        cyc();
        mid();
        reset_n = 1'b0;
        #1;
        chk("ar_read",  {31'd0, mem_read}, 32'd0);
        chk("ar_stall", {31'd0, stall}, 32'd0);
        chk("ar_addr",  mem_address, 32'd0);
        chk("ar_word",  instruction_word, 32'd0);
        chk("ar_fault", {31'd0, fetch_fault}, 32'd0);
        chk("ar_wcnt",  wait_count, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        mreset();
        drive(1'b1, 1'b1, 32'hBFC0_0010, 1'b0, 32'hDEAD_BEEF);
        mid();
        chk("ar_late", instruction_word, 32'd0);
        adv();
        drive(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 32'h2402_0005);
        mid();
        chk("ar_clean_addr", mem_address, 32'hBFC0_0000);
        chk("ar_clean_word", instruction_word, 32'h2402_0005);
        adv();

        // Five back-to-back zero-wait FETCH/EXEC pairs
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 32'hBFC0_0000 + 32'(i * 4), 1'b0, $urandom);
            cyc();
            drive(1'b1, 1'b1, 32'hBFC0_0000 + 32'(i * 4), 1'b0, $urandom);
            cyc();
        end
        mid();
        chk("b2b_fcnt", fetch_count, C_PERF ? 32'd5 : 32'd0);
        adv();

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), ($urandom_range(0, 9) != 0),
                  {$urandom_range(0, 32'h3FFF_FFFF), ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b00},
                  ($urandom_range(0, 9) < 4), $urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_cpu_ifetch.md
# mips_cpu_ifetch

Instruction fetch unit between the program counter and the instruction-side memory bus. During the FETCH phase it issues one word read at the PC's current address on an Avalon-style bus with waitrequest. It captures the returned instruction and holds it stable through EXEC. It raises `stall` while the bus holds off, which freezes the PC and the control path.

## Interface
Parameters:
- `RESET_WORD`, default 32'h0000_0000: value of `instruction_word` after reset (a NOP).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `state`  in  1  CPU phase; 0 = FETCH, 1 = EXEC.
- `active`  in  1  CPU running flag from the PC block.
- `pc_addr`  in  32  byte address of the instruction to fetch.
- `mem_waitrequest`  in  1  slave hold-off.
- `mem_readdata`  in  32  read data; valid in any cycle where `mem_read`=1 and `mem_waitrequest`=0.
- `mem_address`  out  32  bus address.
- `mem_read`  out  1  bus read strobe.
- `mem_byteenable`  out  4  fixed 4'hF while `mem_read`=1, else 4'h0.
- `instruction_word`  out  32  fetched instruction to the PC, branch control and decode.
- `stall`  out  1  fetch outstanding; the PC must hold.
- `fetch_fault`  out  1  sticky flag for a misaligned fetch address.
- `fetch_count`  out  32  completed-fetch counter (see Configuration).
- `wait_count`  out  32  bus wait-cycle counter (see Configuration).

## Operation
- The FSM has three states: IDLE, WAIT and HELD.
- IDLE:
  - A fetch launches when `state`=0, `active`=1 and `pc_addr[1:0]`=0.
  - `mem_read`=1 and `mem_address`=`pc_addr` are driven combinationally in that same cycle.
  - If `mem_waitrequest`=0, capture `mem_readdata` into the instruction register and go to HELD.
  - Otherwise latch `pc_addr` into `addr_q` and go to WAIT.
- WAIT:
  - `mem_read`=1 and `mem_address`=`addr_q`, held stable.
  - On `mem_waitrequest`=0, capture the data and go to HELD.
- HELD:
  - `mem_read`=0.
  - On `state`=1, go to IDLE. The next FETCH phase then starts a new fetch.
- `instruction_word`:
  - Equals `mem_readdata` in the completing cycle (the bypass), and the instruction register otherwise.
  - It is therefore valid at the end of every FETCH cycle in which `stall`=0.
- `stall` = `mem_read` & `mem_waitrequest`.
- Misaligned address (`pc_addr[1:0]`≠0) while `state`=0 and `active`=1 in IDLE:
  - No bus read is issued.
  - `fetch_fault` is set (sticky until reset).
  - `instruction_word` is forced to `RESET_WORD`.
  - The FSM goes to HELD and `stall`=0.
- When `active`=0 (including after the exit address 0), no fetch is issued, `stall`=0 and the FSM stays in IDLE.

## Timing
- Reset values:
  - FSM = IDLE.
  - `mem_read`=0, `mem_address`=0, `mem_byteenable`=0.
  - `instruction_word`=`RESET_WORD`.
  - `stall`=0, `fetch_fault`=0, both counters 0.
- Fetch latency is 1 cycle for a zero-wait slave. With N waitrequest cycles it is N+1 cycles, and `stall`=1 for exactly N cycles.
- `mem_address` does not change while `mem_read`=1 and `mem_waitrequest`=1.
- If `state` goes to 1 while in WAIT (a protocol error upstream), the FSM stays in WAIT until completion and `stall` stays asserted.
- Asynchronous reset during WAIT drops `mem_read` immediately. The in-flight read is abandoned and any late data is ignored.
- Only one read is outstanding at a time; no pipelining.

## Configuration
- `MIPS_CPU_IFETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every completed bus fetch.
  - `wait_count` increments on every cycle with `stall`=1.
  - Both are 32-bit and wrap 32'hFFFF_FFFF→0.
- Undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Shared package `mips_cpu_pkg` holds:
  - the `ifetch_state_t` enum (IDLE, WAIT, HELD);
  - `BE_WORD` = 4'hF;
  - `RESET_VECTOR` = 32'hBFC0_0000, shared with the PC block.
- One sub-module, `mips_cpu_ifetch_perf`, holds both counters and is instantiated only under the macro.

## Test plan
- Zero-wait slave; reset, then `pc_addr`=32'hBFC0_0000, `state`=0 → same cycle `mem_read`=1, `stall`=0, `instruction_word`=`mem_readdata` (32'h2402_0005); value holds through EXEC.
- Slave asserts waitrequest for 3 cycles → `stall`=1 for exactly 3 cycles, `mem_address` stable, word captured on cycle 4, `wait_count`=3 (macro on).
- `pc_addr`=32'hBFC0_0002 → no `mem_read`, `fetch_fault`=1, `instruction_word`=0, `stall`=0.
- `active`=0 with `pc_addr`=0 → no bus activity for 10 cycles, `stall`=0.
- `reset_n` pulsed low mid-WAIT → `mem_read`=0 asynchronously, outputs at reset values, the next fetch is clean.
- 5 back-to-back FETCH/EXEC pairs → `fetch_count`=5 with the macro defined, 0 without.
